// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receive frame engine.
package uart_rx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_e;

    localparam int PRESCALE_8     = 8;
    localparam int PRESCALE_16    = 16;
    localparam int PRESCALE_32    = 32;
    localparam int DATA_WIDTH_DEF = 8;

endpackage

// File: rtl/uart_rx_if.sv
// Receive-side bus: serial line and frame configuration in, byte and status out.
interface uart_rx_if #(
    parameter int DATA_WIDTH = uart_rx_pkg::DATA_WIDTH_DEF,
    parameter int PRESCALE_W = 6
);
    logic                  RX_IN;
    logic [PRESCALE_W-1:0] Prescale;
    logic                  PAR_EN;
    logic                  PAR_TYP;
    logic [DATA_WIDTH-1:0] P_DATA;
    logic                  Data_Valid;
    logic                  Par_Err;
    logic                  Stp_Err;

    modport master (
        output RX_IN, Prescale, PAR_EN, PAR_TYP,
        input  P_DATA, Data_Valid, Par_Err, Stp_Err
    );

    modport slave (
        input  RX_IN, Prescale, PAR_EN, PAR_TYP,
        output P_DATA, Data_Valid, Par_Err, Stp_Err
    );
endinterface

// File: rtl/uart_rx_sampler.sv
// Three-sample majority voter around the middle of each bit period.
module uart_rx_sampler #(
    parameter int PRESCALE_W = 6
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RX_IN,
    input  logic [PRESCALE_W-1:0] edge_cnt,
    input  logic [PRESCALE_W-1:0] Prescale,
    output logic                  sampled_bit
);
    logic [PRESCALE_W-1:0] mid;
    logic                  s0_q, s0_d;
    logic                  s1_q, s1_d;
    logic                  bit_q, bit_d;

    always_comb begin
        mid   = Prescale >> 1;
        s0_d  = s0_q;
        s1_d  = s1_q;
        bit_d = bit_q;
        if (edge_cnt == mid - PRESCALE_W'(1)) s0_d = RX_IN;
        if (edge_cnt == mid)                  s1_d = RX_IN;
        // The third sample is the live line value, voted and registered in one step.
        if (edge_cnt == mid + PRESCALE_W'(1))
            bit_d = (s0_q & s1_q) | (s0_q & RX_IN) | (s1_q & RX_IN);
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            s0_q  <= 1'b1;
            s1_q  <= 1'b1;
            bit_q <= 1'b1;
        end else begin
            s0_q  <= s0_d;
            s1_q  <= s1_d;
            bit_q <= bit_d;
        end
    end

    assign sampled_bit = bit_q;
endmodule

// File: rtl/uart_rx_frame.sv
// UART receive frame engine: start detect, LSB-first deserialize, parity/stop check.
// Define UART_RX_SYNC_EN to insert a 2-flop synchronizer on RX_IN.
module uart_rx_frame
    import uart_rx_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int PRESCALE_W = 6
) (
    input logic      CLK,
    input logic      RST,
    uart_rx_if.slave rx
);
    localparam int             BCW      = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [BCW-1:0] LAST_BIT = BCW'(DATA_WIDTH - 1);

    rx_state_e             state_q, state_d;
    logic [PRESCALE_W-1:0] edge_cnt_q, edge_cnt_d;
    logic [BCW-1:0]        bit_cnt_q, bit_cnt_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [DATA_WIDTH-1:0] p_data_q, p_data_d;
    logic                  valid_q, valid_d;
    logic                  par_err_q, par_err_d;
    logic                  stp_err_q, stp_err_d;
    logic [PRESCALE_W-1:0] prescale_q, prescale_d;
    logic                  par_en_q, par_en_d;
    logic                  par_typ_q, par_typ_d;

    logic                  rx_line;
    logic                  sampled_bit;
    logic                  bit_end;
    logic                  enter_start;
    logic                  exp_par;

`ifdef UART_RX_SYNC_EN
    logic [1:0] sync_q, sync_d;

    always_comb sync_d = {sync_q[0], rx.RX_IN};

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) sync_q <= 2'b11;
        else      sync_q <= sync_d;
    end

    assign rx_line = sync_q[1];
`else
    assign rx_line = rx.RX_IN;
`endif

    uart_rx_sampler #(.PRESCALE_W(PRESCALE_W)) u_sampler (
        .CLK         (CLK),
        .RST         (RST),
        .RX_IN       (rx_line),
        .edge_cnt    (edge_cnt_q),
        .Prescale    (prescale_q),
        .sampled_bit (sampled_bit)
    );

    // NOTE: every _d gets its hold value first so no path through this block infers a latch.
    always_comb begin
        state_d     = state_q;
        edge_cnt_d  = edge_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        p_data_d    = p_data_q;
        valid_d     = 1'b0;
        par_err_d   = par_err_q;
        stp_err_d   = stp_err_q;
        prescale_d  = prescale_q;
        par_en_d    = par_en_q;
        par_typ_d   = par_typ_q;
        enter_start = 1'b0;
        bit_end     = (edge_cnt_q == prescale_q - PRESCALE_W'(1));
        exp_par     = par_typ_q ? ~^shift_q : ^shift_q;

        if (state_q != IDLE) edge_cnt_d = bit_end ? '0 : edge_cnt_q + PRESCALE_W'(1);

        unique case (state_q)
            IDLE: enter_start = !rx_line;
            START: begin
                // First cycle the registered vote for the start bit is visible.
                if (edge_cnt_q == (prescale_q >> 1) + PRESCALE_W'(2) && sampled_bit) begin
                    state_d    = IDLE;
                    edge_cnt_d = '0;
                end else if (bit_end) begin
                    state_d   = DATA;
                    bit_cnt_d = '0;
                end
            end
            DATA: begin
                if (bit_end) begin
                    shift_d[bit_cnt_q] = sampled_bit;
                    if (bit_cnt_q == LAST_BIT) begin
                        bit_cnt_d = '0;
                        state_d   = par_en_q ? PARITY : STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BCW'(1);
                    end
                end
            end
            PARITY: begin
                if (bit_end) begin
                    par_err_d = (sampled_bit != exp_par);
                    state_d   = STOP;
                end
            end
            STOP: begin
                if (bit_end) begin
                    stp_err_d = !sampled_bit;
                    if (!par_err_q && sampled_bit) begin
                        p_data_d = shift_q;
                        valid_d  = 1'b1;
                    end
                    if (!rx_line) enter_start = 1'b1;
                    else          state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Frame configuration is frozen for the whole frame from start detection on.
        if (enter_start) begin
            state_d    = START;
            edge_cnt_d = '0;
            par_err_d  = 1'b0;
            stp_err_d  = 1'b0;
            prescale_d = rx.Prescale;
            par_en_d   = rx.PAR_EN;
            par_typ_d  = rx.PAR_TYP;
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update from the same pre-edge values.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q    <= IDLE;
            edge_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            p_data_q   <= '0;
            valid_q    <= 1'b0;
            par_err_q  <= 1'b0;
            stp_err_q  <= 1'b0;
            prescale_q <= PRESCALE_W'(PRESCALE_8);
            par_en_q   <= 1'b0;
            par_typ_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            edge_cnt_q <= edge_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            p_data_q   <= p_data_d;
            valid_q    <= valid_d;
            par_err_q  <= par_err_d;
            stp_err_q  <= stp_err_d;
            prescale_q <= prescale_d;
            par_en_q   <= par_en_d;
            par_typ_q  <= par_typ_d;
        end
    end

    assign rx.P_DATA     = p_data_q;
    assign rx.Data_Valid = valid_q;
    assign rx.Par_Err    = par_err_q;
    assign rx.Stp_Err    = stp_err_q;
endmodule

// File: tb/tb_uart_rx_frame.sv
// Self-checking bench for uart_rx_frame: directed scenarios plus randomized frames vs a frame-level model.
module tb_uart_rx_frame;
    import uart_rx_pkg::*;

`ifdef UART_RX_SYNC_EN
    localparam int SYNC_LAT = 2;
`else
    localparam int SYNC_LAT = 0;
`endif

    typedef struct {
        logic [7:0] d;
        int         c;
    } dv_t;

    logic       clk;
    logic       rst_n;
    int         cyc = 0;
    int         n_checks = 0;
    int         n_fail = 0;
    logic [7:0] exp_pdata;
    dv_t        dv_q[$];

    uart_rx_if #(.DATA_WIDTH(8), .PRESCALE_W(6)) bus ();

    uart_rx_frame #(.DATA_WIDTH(8), .PRESCALE_W(6)) dut (
        .CLK (clk),
        .RST (rst_n),
        .rx  (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Every cycle with the strobe high is logged, so a stretched pulse shows up as an extra entry.
    always @(negedge clk) begin
        if (bus.Data_Valid === 1'b1) begin
            dv_t e;
            e.d = bus.P_DATA;
            e.c = cyc;
            dv_q.push_back(e);
        end
    end

    function automatic int pick_pre();
        case ($urandom_range(0, 2))
            0:       return PRESCALE_8;
            1:       return PRESCALE_16;
            default: return PRESCALE_32;
        endcase
    endfunction

    // Drives one frame at bit rate pre; fall = cycle stamp of the first edge that sees the start bit.
    task automatic send_frame(input logic [7:0] d, input int pre, input bit pen, input bit ptyp,
                              input bit pbit, input bit sbit, input bit scramble, output int fall);
        bus.Prescale = 6'(pre);
        bus.PAR_EN   = pen;
        bus.PAR_TYP  = ptyp;
        bus.RX_IN    = 1'b0;
        fall = cyc + 1;
        repeat (pre) @(negedge clk);
        if (scramble) begin
            bus.Prescale = 6'(pick_pre());
            bus.PAR_EN   = ~pen;
            bus.PAR_TYP  = ~ptyp;
        end
        for (int i = 0; i < 8; i++) begin
            bus.RX_IN = d[i];
            repeat (pre) @(negedge clk);
        end
        if (pen) begin
            bus.RX_IN = pbit;
            repeat (pre) @(negedge clk);
        end
        bus.RX_IN = sbit;
        repeat (pre) @(negedge clk);
        bus.RX_IN = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.RX_IN = 1'b1; bus.Prescale = 6'(PRESCALE_8); bus.PAR_EN = 1'b0; bus.PAR_TYP = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++; if (bus.P_DATA !== 8'h00) begin n_fail++; $display("FAIL reset_pdata: got %h expected 00", bus.P_DATA); end
        n_checks++; if (bus.Data_Valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", bus.Data_Valid); end
        n_checks++; if (bus.Par_Err !== 1'b0) begin n_fail++; $display("FAIL reset_par_err: got %b expected 0", bus.Par_Err); end
        n_checks++; if (bus.Stp_Err !== 1'b0) begin n_fail++; $display("FAIL reset_stp_err: got %b expected 0", bus.Stp_Err); end
        rst_n = 1'b1;
        exp_pdata = 8'h00;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_even_parity();
        int fall;
        dv_q.delete();
        send_frame(8'hA5, 8, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, fall);
        repeat (6) @(negedge clk);
        exp_pdata = 8'hA5;
        n_checks++; if (dv_q.size() != 1) begin n_fail++; $display("FAIL even_valid_count: got %0d expected 1", dv_q.size()); end
        if (dv_q.size() > 0) begin
            n_checks++; if (dv_q[0].d !== 8'hA5) begin n_fail++; $display("FAIL even_data: got %h expected a5", dv_q[0].d); end
            n_checks++; if (dv_q[0].c - fall != 88 + SYNC_LAT) begin n_fail++; $display("FAIL even_latency: got %0d expected %0d", dv_q[0].c - fall, 88 + SYNC_LAT); end
        end
        n_checks++; if (bus.Par_Err !== 1'b0) begin n_fail++; $display("FAIL even_par_err: got %b expected 0", bus.Par_Err); end
        n_checks++; if (bus.Stp_Err !== 1'b0) begin n_fail++; $display("FAIL even_stp_err: got %b expected 0", bus.Stp_Err); end
    endtask

    task automatic test_parity_error();
        int fall;
        dv_q.delete();
        send_frame(8'hA5, 8, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, fall);
        repeat (6) @(negedge clk);
        n_checks++; if (dv_q.size() != 0) begin n_fail++; $display("FAIL parerr_valid_count: got %0d expected 0", dv_q.size()); end
        n_checks++; if (bus.Par_Err !== 1'b1) begin n_fail++; $display("FAIL parerr_flag: got %b expected 1", bus.Par_Err); end
        n_checks++; if (bus.Stp_Err !== 1'b0) begin n_fail++; $display("FAIL parerr_stp_err: got %b expected 0", bus.Stp_Err); end
        n_checks++; if (bus.P_DATA !== exp_pdata) begin n_fail++; $display("FAIL parerr_pdata_hold: got %h expected %h", bus.P_DATA, exp_pdata); end
    endtask

    task automatic test_stop_error();
        int fall;
        dv_q.delete();
        send_frame(8'h3C, 16, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, fall);
        repeat (6) @(negedge clk);
        n_checks++; if (dv_q.size() != 0) begin n_fail++; $display("FAIL stperr_valid_count: got %0d expected 0", dv_q.size()); end
        n_checks++; if (bus.Stp_Err !== 1'b1) begin n_fail++; $display("FAIL stperr_flag: got %b expected 1", bus.Stp_Err); end
        n_checks++; if (bus.Par_Err !== 1'b0) begin n_fail++; $display("FAIL stperr_par_cleared: got %b expected 0", bus.Par_Err); end
        n_checks++; if (bus.P_DATA !== exp_pdata) begin n_fail++; $display("FAIL stperr_pdata_hold: got %h expected %h", bus.P_DATA, exp_pdata); end
        fork
            send_frame(8'h55, 16, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, fall);
            begin
                repeat (8) @(negedge clk);
                n_checks++; if (bus.Stp_Err !== 1'b0) begin n_fail++; $display("FAIL stperr_clear_at_start: got %b expected 0", bus.Stp_Err); end
            end
        join
        repeat (6) @(negedge clk);
        exp_pdata = 8'h55;
        n_checks++; if (dv_q.size() != 1) begin n_fail++; $display("FAIL recover_valid_count: got %0d expected 1", dv_q.size()); end
        if (dv_q.size() > 0) begin
            n_checks++; if (dv_q[0].d !== 8'h55) begin n_fail++; $display("FAIL recover_data: got %h expected 55", dv_q[0].d); end
            n_checks++; if (dv_q[0].c - fall != 160 + SYNC_LAT) begin n_fail++; $display("FAIL recover_latency: got %0d expected %0d", dv_q[0].c - fall, 160 + SYNC_LAT); end
        end
    endtask

    task automatic test_start_glitch();
        int fall;
        dv_q.delete();
        bus.Prescale = 6'(PRESCALE_8); bus.PAR_EN = 1'b0; bus.PAR_TYP = 1'b0;
        bus.RX_IN = 1'b0;
        repeat (2) @(negedge clk);
        bus.RX_IN = 1'b1;
        repeat (20) @(negedge clk);
        n_checks++; if (dv_q.size() != 0) begin n_fail++; $display("FAIL glitch_valid_count: got %0d expected 0", dv_q.size()); end
        n_checks++; if (bus.Par_Err !== 1'b0 || bus.Stp_Err !== 1'b0) begin n_fail++; $display("FAIL glitch_flags: got par=%b stp=%b expected 0/0", bus.Par_Err, bus.Stp_Err); end
        n_checks++; if (bus.P_DATA !== exp_pdata) begin n_fail++; $display("FAIL glitch_pdata_hold: got %h expected %h", bus.P_DATA, exp_pdata); end
        send_frame(8'h0F, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, fall);
        repeat (6) @(negedge clk);
        exp_pdata = 8'h0F;
        n_checks++; if (dv_q.size() != 1 || dv_q[0].d !== 8'h0F) begin n_fail++; $display("FAIL glitch_next_frame: got count %0d data %h expected 1 0f", dv_q.size(), bus.P_DATA); end
        if (dv_q.size() > 0) begin
            n_checks++; if (dv_q[0].c - fall != 80 + SYNC_LAT) begin n_fail++; $display("FAIL glitch_next_latency: got %0d expected %0d", dv_q[0].c - fall, 80 + SYNC_LAT); end
        end
    endtask

    task automatic test_back_to_back();
        int fall0, fall1;
        dv_q.delete();
        send_frame(8'h3C, 16, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, fall0);
        send_frame(8'hC3, 16, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, fall1);
        repeat (6) @(negedge clk);
        exp_pdata = 8'hC3;
        n_checks++; if (dv_q.size() != 2) begin n_fail++; $display("FAIL b2b_valid_count: got %0d expected 2", dv_q.size()); end
        if (dv_q.size() == 2) begin
            n_checks++; if (dv_q[0].d !== 8'h3C) begin n_fail++; $display("FAIL b2b_first_data: got %h expected 3c", dv_q[0].d); end
            n_checks++; if (dv_q[1].d !== 8'hC3) begin n_fail++; $display("FAIL b2b_second_data: got %h expected c3", dv_q[1].d); end
            n_checks++; if (dv_q[1].c - dv_q[0].c != 160) begin n_fail++; $display("FAIL b2b_spacing: got %0d expected 160", dv_q[1].c - dv_q[0].c); end
            n_checks++; if (dv_q[0].c - fall0 != 160 + SYNC_LAT) begin n_fail++; $display("FAIL b2b_latency: got %0d expected %0d", dv_q[0].c - fall0, 160 + SYNC_LAT); end
        end
    endtask

    task automatic test_reset_mid_frame();
        int         fall;
        logic [7:0] d;
        d = 8'h5A;
        dv_q.delete();
        bus.Prescale = 6'(PRESCALE_16); bus.PAR_EN = 1'b0; bus.PAR_TYP = 1'b0;
        bus.RX_IN = 1'b0;
        repeat (16) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            bus.RX_IN = d[i];
            repeat (16) @(negedge clk);
        end
        bus.RX_IN = d[4];
        repeat (8) @(negedge clk);
        rst_n = 1'b0;
        #1;
        exp_pdata = 8'h00;
        n_checks++; if (bus.P_DATA !== 8'h00 || bus.Data_Valid !== 1'b0 || bus.Par_Err !== 1'b0 || bus.Stp_Err !== 1'b0) begin
            n_fail++; $display("FAIL midreset_outputs: got pdata=%h dv=%b par=%b stp=%b expected all 0", bus.P_DATA, bus.Data_Valid, bus.Par_Err, bus.Stp_Err);
        end
        @(negedge clk);
        bus.RX_IN = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        send_frame(8'h81, 32, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, fall);
        repeat (6) @(negedge clk);
        exp_pdata = 8'h81;
        n_checks++; if (dv_q.size() != 1) begin n_fail++; $display("FAIL midreset_valid_count: got %0d expected 1", dv_q.size()); end
        if (dv_q.size() > 0) begin
            n_checks++; if (dv_q[0].d !== 8'h81) begin n_fail++; $display("FAIL midreset_data: got %h expected 81", dv_q[0].d); end
            n_checks++; if (dv_q[0].c - fall != 320 + SYNC_LAT) begin n_fail++; $display("FAIL midreset_latency: got %0d expected %0d", dv_q[0].c - fall, 320 + SYNC_LAT); end
        end
    endtask

    // Model: parity bit should make the count of ones even (PAR_TYP=0) or odd (PAR_TYP=1).
    task automatic test_random_frames();
        int         fall, pre;
        logic [7:0] d;
        bit         pen, ptyp, good_par, pbit, sbit, exp_perr, exp_serr, exp_valid;
        for (int n = 0; n < 12; n++) begin
            d         = 8'($urandom);
            pre       = pick_pre();
            pen       = 1'($urandom_range(0, 1));
            ptyp      = 1'($urandom_range(0, 1));
            good_par  = 1'(($countones(d) % 2 == 1) ^ ptyp);
            pbit      = ($urandom_range(0, 3) == 0) ? ~good_par : good_par;
            sbit      = ($urandom_range(0, 5) != 0);
            exp_perr  = pen && (pbit != good_par);
            exp_serr  = !sbit;
            exp_valid = !exp_perr && !exp_serr;
            dv_q.delete();
            send_frame(d, pre, pen, ptyp, pbit, sbit, 1'b1, fall);
            repeat (6) @(negedge clk);
            if (exp_valid) exp_pdata = d;
            n_checks++; if (dv_q.size() != int'(exp_valid)) begin n_fail++; $display("FAIL rand%0d_valid_count: got %0d expected %0d", n, dv_q.size(), exp_valid); end
            if (exp_valid && dv_q.size() > 0) begin
                n_checks++; if (dv_q[0].d !== d) begin n_fail++; $display("FAIL rand%0d_data: got %h expected %h", n, dv_q[0].d, d); end
                n_checks++; if (dv_q[0].c - fall != (10 + int'(pen)) * pre + SYNC_LAT) begin
                    n_fail++; $display("FAIL rand%0d_latency: got %0d expected %0d", n, dv_q[0].c - fall, (10 + int'(pen)) * pre + SYNC_LAT);
                end
            end
            n_checks++; if (bus.P_DATA !== exp_pdata) begin n_fail++; $display("FAIL rand%0d_pdata: got %h expected %h", n, bus.P_DATA, exp_pdata); end
            n_checks++; if (bus.Par_Err !== exp_perr) begin n_fail++; $display("FAIL rand%0d_par_err: got %b expected %b", n, bus.Par_Err, exp_perr); end
            n_checks++; if (bus.Stp_Err !== exp_serr) begin n_fail++; $display("FAIL rand%0d_stp_err: got %b expected %b", n, bus.Stp_Err, exp_serr); end
            repeat ($urandom_range(1, 6)) @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_even_parity();
        test_parity_error();
        test_stop_error();
        test_start_glitch();
        test_back_to_back();
        test_reset_mid_frame();
        test_random_frames();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/uart_rx_frame.md
Name: uart_rx_frame

Overview:
- UART receive frame engine; the receive-side counterpart of the TX parity/serializer path.
- Oversamples RX_IN, detects the start bit and deserializes 8 data bits LSB-first.
- Checks the optional parity bit and the stop bit, then presents the byte with a one-cycle valid strobe.
- Sits between the RX pad (or synchronizer) and the RX FIFO / system controller.

Parameters:
- DATA_WIDTH, 8, number of data bits per frame.
- PRESCALE_W, 6, width of the Prescale input. Legal Prescale values are 8, 16 and 32.

Ports:
- CLK  in  1  receive oversampling clock.
- RST  in  1  reset, asynchronous, active-low.
- RX_IN  in  1  serial line; idle high.
- Prescale  in  PRESCALE_W  oversampling ratio (CLK cycles per bit).
- PAR_EN  in  1  1 = frame carries a parity bit.
- PAR_TYP  in  1  0 = even parity, 1 = odd parity.
- P_DATA  out  DATA_WIDTH  received byte.
- Data_Valid  out  1  one-cycle strobe; P_DATA is good.
- Par_Err  out  1  parity mismatch in the last frame.
- Stp_Err  out  1  stop bit sampled low in the last frame.

Behaviour:
- Reset (RST=0, async): state=IDLE, all counters 0, P_DATA=0, Data_Valid=0, Par_Err=0, Stp_Err=0.
- Counters:
  - edge_cnt runs 0..Prescale-1 per bit period.
  - bit_cnt counts data bits 0..DATA_WIDTH-1.
- Sampling:
  - Each bit value is the majority of 3 samples taken at edge_cnt = Prescale/2-1, Prescale/2 and Prescale/2+1.
  - The sampled value is registered at Prescale/2+1.
- FSM:
  - IDLE: when RX_IN=0, go to START with edge_cnt=0. Prescale, PAR_EN and PAR_TYP are latched here; changes mid-frame are ignored.
  - START:
    - If the sampled bit is 1, the start was a glitch: return to IDLE at the sample point. No flags change.
    - Otherwise, at edge_cnt=Prescale-1, go to DATA.
    - On entering START, Par_Err and Stp_Err clear.
  - DATA: shift the sampled bit into the shift register at bit position bit_cnt (LSB first). After bit DATA_WIDTH-1 ends, go to PARITY if PAR_EN, else STOP.
  - PARITY:
    - Expected bit = ^data when even (PAR_TYP=0); expected bit = ~^data when odd (PAR_TYP=1).
    - On mismatch, Par_Err=1 from the end of the bit period.
    - Go to STOP.
  - STOP:
    - Sampled 0 sets Stp_Err=1.
    - At edge_cnt=Prescale-1: if Par_Err=0 and Stp_Err=0, load P_DATA and pulse Data_Valid high for exactly the following CLK cycle.
    - Next state: START if RX_IN=0 at that edge (back-to-back frame), else IDLE.
- Error frames: no Data_Valid, and P_DATA holds its previous value. Par_Err and Stp_Err hold until the next start detection.
- Frame length: (1 + DATA_WIDTH + PAR_EN + 1) × Prescale cycles, measured from the falling edge to the end of the stop bit.
- Illegal Prescale value: behaviour undefined. The bench must not drive one.

Optional Feature:
- Macro: UART_RX_SYNC_EN.
- Defined: RX_IN passes through a 2-flop synchronizer (reset value 1) before all logic, adding 2 CLK cycles of latency to every event.
- Undefined: RX_IN is used directly and is assumed to be synchronous to CLK.

Decomposition:
- Package uart_rx_pkg holds:
  - enum rx_state_e {IDLE, START, DATA, PARITY, STOP};
  - constants PRESCALE_8/16/32;
  - localparam DATA_WIDTH_DEF=8.
- Sub-module uart_rx_sampler holds the 3-sample majority voter. Inputs: CLK, RST, RX_IN, edge_cnt, Prescale. Output: sampled_bit.

Test Plan:
- Even parity, correct frame: Prescale=8, PAR_EN=1, PAR_TYP=0, frame start 0, bits 1,0,1,0,0,1,0,1, parity 0, stop 1 -> P_DATA=0xA5, Data_Valid high 1 cycle, exactly 88 CLK after the falling edge; Par_Err=0, Stp_Err=0.
- Parity mismatch: same frame but PAR_TYP=1 -> Par_Err=1, no Data_Valid, P_DATA unchanged.
- Stop-bit error: Prescale=16, PAR_EN=0, byte 0x3C with stop bit 0 -> Stp_Err=1, no Data_Valid; the next good frame 0x55 clears Stp_Err at its start and yields Data_Valid.
- Start glitch: Prescale=8, RX_IN low for 2 CLK then high -> FSM back in IDLE, no flags, no Data_Valid.
- Back-to-back frames: Prescale=16, PAR_EN=0, frames 0x3C then 0xC3 with no idle gap -> two Data_Valid pulses 160 CLK apart, values 0x3C then 0xC3.
- Reset mid-frame: RST low during DATA bit 4 -> all outputs 0 immediately; after release, a full 0x81 frame at Prescale=32 is received correctly.
